// File: rtl/spm_pkg.sv
// Shared types and helpers for the serial-parallel multiplier sequencer.
// Holds the FSM state encoding and the bit-counter width function.
package spm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } spm_state_t;

  // Counter must reach 2N+LAT without wrapping.
  function automatic int spm_cnt_w(input int n, input int lat);
    return $clog2(2 * n + lat + 1);
  endfunction

endpackage

// File: rtl/spm_seq_ctrl_if.sv
// Request/response bundle between the datapath and the multiply sequencer.
// master: start, mcand, mplier out; busy, done, product in. slave: mirrored.
interface spm_seq_ctrl_if #(
  parameter int N = 32
);

  logic           start;
  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  modport master (
    output start, mcand, mplier,
    input  busy, done, product
  );

  modport slave (
    input  start, mcand, mplier,
    output busy, done, product
  );

endinterface

// File: rtl/spm_deser.sv
// W-bit shift-in register: new bit enters at the MSB, contents move right.
// Ports: clk_i, rst_i (sync, high), clr_i, en_i, din_i in; q_o out.
module spm_deser #(
  parameter int W = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         din_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= {din_i, data_q[W-1:1]};
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/spm_seq_ctrl.sv
// Sequencer wrapping a serial-parallel multiplier core as a start/done unit.
// Ports: clk, rst (sync, high), bus (slave: start/mcand/mplier/busy/done/
// product), spm_rst/spm_x/spm_y to the core, spm_prod from the core.
// Build option SPM_SEQ_CTRL_OVF_EN adds output ovf (result exceeds N bits).
module spm_seq_ctrl
  import spm_pkg::*;
#(
  parameter int N       = 32,
  parameter int SPM_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  spm_seq_ctrl_if.slave bus,
  output logic         spm_rst,
  output logic [N-1:0] spm_x,
  output logic         spm_y,
  input  logic         spm_prod
`ifdef SPM_SEQ_CTRL_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int W  = 2 * N;
  localparam int CW = spm_cnt_w(N, SPM_LAT);
  localparam int IW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(W + SPM_LAT - 1);
  localparam logic [CW-1:0] LAT  = CW'(SPM_LAT);

  spm_state_t    state_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  x_q;
  logic [N-1:0]  mreg_q;
  logic          y_q;
  logic          busy_q;
  logic          done_q;
  logic [W-1:0]  prod;

  logic          accept;
  logic          sh_en;
  logic [CW-1:0] cnt_nx;
  logic          y_nx;

  assign accept = (state_q == IDLE) && bus.start;
  assign sh_en  = (state_q == SHIFT) && (cnt_q >= LAT);
  assign cnt_nx = (state_q == SHIFT) ? cnt_q + CW'(1) : '0;

  // spm_y is registered, so it is prepared for the count of the next
  // cycle: multiplier bits, then sign extension, then zero flush.
  always_comb begin
    y_nx = 1'b0;
    if (cnt_nx < CW'(N)) begin
      y_nx = mreg_q[cnt_nx[IW-1:0]];
    end else if (cnt_nx < CW'(W)) begin
      y_nx = mreg_q[N-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      mreg_q  <= '0;
      y_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            x_q     <= bus.mcand;
            mreg_q  <= bus.mplier;
            busy_q  <= 1'b1;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          cnt_q   <= '0;
          y_q     <= y_nx;
          state_q <= SHIFT;
        end
        SHIFT: begin
          cnt_q <= cnt_nx;
          if (cnt_q == LAST) begin
            y_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            y_q <= y_nx;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  spm_deser #(
    .W(W)
  ) u_deser (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (accept),
    .en_i  (sh_en),
    .din_i (spm_prod),
    .q_o   (prod)
  );

`ifdef SPM_SEQ_CTRL_OVF_EN
  logic       ovf_q;
  logic [N:0] top_nx;

  // Top N+1 bits of the product as they will be after the final shift,
  // so ovf is valid together with done.
  assign top_nx = {spm_prod, prod[W-1:N]};

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      ovf_q <= 1'b0;
    end else if (state_q == SHIFT && cnt_q == LAST) begin
      ovf_q <= !((top_nx == '0) || (top_nx == '1));
    end
  end

  assign ovf = ovf_q;
`endif

  assign spm_rst     = rst || (state_q == CLEAR);
  assign spm_x       = x_q;
  assign spm_y       = y_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = prod;

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// Bench for spm_seq_ctrl: N=8 with SPM_LAT=1 (dut_a) and SPM_LAT=3 (dut_b),
// each fed by a behavioural serial-parallel core model.
module tb_spm_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spm_seq_ctrl_if #(.N(8)) ifa ();
  spm_seq_ctrl_if #(.N(8)) ifb ();

  logic       spm_rst_a, spm_y_a, spm_prod_a;
  logic       spm_rst_b, spm_y_b, spm_prod_b;
  logic [7:0] spm_x_a, spm_x_b;
`ifdef SPM_SEQ_CTRL_OVF_EN
  logic       ovf_a, ovf_b;
`endif

  spm_seq_ctrl #(.N(8), .SPM_LAT(1)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .bus      (ifa),
    .spm_rst  (spm_rst_a),
    .spm_x    (spm_x_a),
    .spm_y    (spm_y_a),
    .spm_prod (spm_prod_a)
`ifdef SPM_SEQ_CTRL_OVF_EN
    ,
    .ovf      (ovf_a)
`endif
  );

  spm_seq_ctrl #(.N(8), .SPM_LAT(3)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .bus      (ifb),
    .spm_rst  (spm_rst_b),
    .spm_x    (spm_x_b),
    .spm_y    (spm_y_b),
    .spm_prod (spm_prod_b)
`ifdef SPM_SEQ_CTRL_OVF_EN
    ,
    .ovf      (ovf_b)
`endif
  );

  // Behavioural core: accumulate sext(x)<<j for each serial y bit j,
  // emit bit j of the running sum, delayed by SPM_LAT registers.
  function automatic logic [15:0] core_acc(
    input logic [15:0] acc, input logic [7:0] x, input logic y, input int j);
    logic [15:0] xs;
    xs = {{8{x[7]}}, x};
    if (y && j < 16) return acc + (xs << j);
    return acc;
  endfunction

  logic [15:0] acc_a = '0, acc_b = '0;
  int          j_a = 0, j_b = 0;
  logic        pipe_a = 1'b0;
  logic [2:0]  pipe_b = '0;

  always @(posedge clk) begin
    if (spm_rst_a) begin
      acc_a = '0;
      j_a = 0;
      pipe_a <= 1'b0;
    end else begin
      acc_a = core_acc(acc_a, spm_x_a, spm_y_a, j_a);
      pipe_a <= (j_a < 16) ? acc_a[j_a] : 1'b0;
      j_a++;
    end
  end

  always @(posedge clk) begin
    if (spm_rst_b) begin
      acc_b = '0;
      j_b = 0;
      pipe_b <= '0;
    end else begin
      acc_b = core_acc(acc_b, spm_x_b, spm_y_b, j_b);
      pipe_b <= {pipe_b[1:0], (j_b < 16) ? acc_b[j_b] : 1'b0};
      j_b++;
    end
  end

  assign spm_prod_a = pipe_a;
  assign spm_prod_b = pipe_b[2];

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] smul(input logic [7:0] a,
                                       input logic [7:0] b);
    logic signed [15:0] sa, sb2;
    sa  = $signed(a);
    sb2 = $signed(b);
    return sa * sb2;
  endfunction

  function automatic logic exp_ovf(input logic [15:0] e);
    return (e[15:7] != 9'h000) && (e[15:7] != 9'h1FF);
  endfunction

  function automatic logic done_of(input bit b);
    return b ? ifb.done : ifa.done;
  endfunction
  function automatic logic busy_of(input bit b);
    return b ? ifb.busy : ifa.busy;
  endfunction
  function automatic logic [15:0] prod_of(input bit b);
    return b ? ifb.product : ifa.product;
  endfunction
  function automatic logic [7:0] x_of(input bit b);
    return b ? spm_x_b : spm_x_a;
  endfunction
`ifdef SPM_SEQ_CTRL_OVF_EN
  function automatic logic ovf_of(input bit b);
    return b ? ovf_b : ovf_a;
  endfunction
`endif

  task automatic drive(input bit b, input logic st,
                       input logic [7:0] mc, input logic [7:0] mp);
    ifa.mcand  = mc;
    ifa.mplier = mp;
    ifb.mcand  = mc;
    ifb.mplier = mp;
    if (b) ifb.start = st;
    else   ifa.start = st;
  endtask

  task automatic run_op(input bit b, input logic [7:0] mc,
                        input logic [7:0] mp, input int lat);
    int k;
    bit bz_ok, x_ok;
    logic [15:0] e;
    @(negedge clk);
    drive(b, 1'b1, mc, mp);
    sb.push_back(smul(mc, mp));
    @(negedge clk);
    drive(b, 1'b0, mc, mp);
    k = 1;
    bz_ok = 1'b1;
    x_ok = 1'b1;
    while (!done_of(b) && k < 100) begin
      if (busy_of(b) !== 1'b1) bz_ok = 1'b0;
      if (x_of(b) !== mc) x_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    chk("done_latency", k, lat);
    chk("busy_during_op", bz_ok, 1);
    chk("spm_x_held", x_ok, 1);
    chk("busy_at_done", busy_of(b), 0);
    e = sb.pop_front();
    chk("product", prod_of(b), e);
`ifdef SPM_SEQ_CTRL_OVF_EN
    chk("ovf", ovf_of(b), exp_ovf(e));
`endif
    @(negedge clk);
    chk("done_one_cycle", done_of(b), 0);
    chk("product_held", prod_of(b), e);
  endtask

  initial begin
    int k;
    logic [15:0] e;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_spm_rst", spm_rst_a, 1);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_done", ifa.done, 0);
    chk("rst_product", ifa.product, 0);
    chk("rst_spm_x", spm_x_a, 0);
    chk("rst_spm_y", spm_y_a, 0);
    chk("rst_product_b", ifb.product, 0);
`ifdef SPM_SEQ_CTRL_OVF_EN
    chk("rst_ovf", ovf_a, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("idle_spm_rst", spm_rst_a, 0);

    run_op(1'b0, 8'd3, 8'd5, 19);
    run_op(1'b0, 8'hFD, 8'd5, 19);
    run_op(1'b0, 8'h80, 8'h80, 19);
    run_op(1'b0, 8'h7F, 8'hFF, 19);
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 19);
    end

    // start held high: the start seen in DONE is ignored, next in cycle 20
    @(negedge clk);
    drive(1'b0, 1'b1, 8'd2, 8'd3);
    sb.push_back(smul(8'd2, 8'd3));
    repeat (19) @(negedge clk);
    chk("hold_done_c19", ifa.done, 1);
    chk("hold_prod1", ifa.product, sb.pop_front());
    drive(1'b0, 1'b1, 8'd9, 8'hFC);
    sb.push_back(smul(8'd9, 8'hFC));
    @(negedge clk);
    chk("hold_idle_c20", ifa.busy, 0);
    chk("hold_prod_c20", ifa.product, 16'h0006);
    @(negedge clk);
    chk("hold_busy_c21", ifa.busy, 1);
    chk("hold_x_c21", spm_x_a, 8'd9);
    drive(1'b0, 1'b0, 8'd0, 8'd0);
    k = 21;
    while (!ifa.done && k < 120) begin
      @(negedge clk);
      k++;
    end
    chk("hold_done_c39", k, 39);
    chk("hold_prod2", ifa.product, sb.pop_front());

    // pulses in cycles 5 and 19 are ignored
    repeat (2) @(negedge clk);
    drive(1'b0, 1'b1, 8'd4, 8'd6);
    sb.push_back(smul(8'd4, 8'd6));
    @(negedge clk);
    drive(1'b0, 1'b0, 8'd4, 8'd6);
    repeat (4) @(negedge clk);
    drive(1'b0, 1'b1, 8'h55, 8'h55);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    chk("pulse5_x_held", spm_x_a, 8'd4);
    repeat (13) @(negedge clk);
    chk("pulse_done_c19", ifa.done, 1);
    e = sb.pop_front();
    chk("pulse_prod", ifa.product, e);
    drive(1'b0, 1'b1, 8'h11, 8'h22);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    chk("pulse19_ignored", ifa.busy, 0);
    repeat (5) @(negedge clk);
    chk("pulse_still_idle", ifa.busy, 0);
    chk("pulse_no_done", ifa.done, 0);
    chk("pulse_prod_kept", ifa.product, e);

    // reset in cycle 10 of an operation
    @(negedge clk);
    drive(1'b0, 1'b1, 8'd5, 8'd6);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'd5, 8'd6);
    repeat (9) @(negedge clk);
    chk("midrst_busy_c10", ifa.busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_spm_rst", spm_rst_a, 1);
    @(negedge clk);
    chk("midrst_busy", ifa.busy, 0);
    chk("midrst_done", ifa.done, 0);
    chk("midrst_product", ifa.product, 0);
    chk("midrst_spm_x", spm_x_a, 0);
    chk("midrst_spm_rst_c11", spm_rst_a, 1);
    rst = 1'b0;
    run_op(1'b0, 8'hF9, 8'hF7, 19);

    // SPM_LAT=3 instance
    run_op(1'b1, 8'd3, 8'd5, 21);
    run_op(1'b1, 8'hFD, 8'd5, 21);
    run_op(1'b1, 8'h80, 8'h80, 21);
    run_op(1'b1, 8'h7F, 8'hFF, 21);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spm_seq_ctrl.md
Name: spm_seq_ctrl

Overview:
- Sequencing stage wrapped around the serial-parallel multiplier core.
- Upstream role: latches the multiplicand and drives it onto the core's parallel input; serializes the multiplier LSB-first onto the core's serial input, sign-extended to 2N bits.
- Downstream role: deserializes the core's serial product into a 2N-bit two's-complement result.
- Presents a start/busy/done handshake to the surrounding datapath, so the core is usable as a single-request multiply unit.

Parameters:
- N, 32: operand width in bits; must be ≥ 2 and match the core's N.
- SPM_LAT, 1: cycles from a serial bit entering spm_y to the corresponding product bit appearing on spm_prod.

Ports:
- clk  in  1  global clock.
- rst  in  1  global reset; synchronous, active-high.
- start  in  1  request pulse; sampled only in IDLE.
- mcand  in  N  multiplicand, two's complement; sampled with start.
- mplier  in  N  multiplier, two's complement; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; product valid from this cycle on.
- product  out  2N  signed result; held until the next accepted start.
- spm_rst  out  1  reset to the core.
- spm_x  out  N  parallel multiplicand to the core.
- spm_y  out  1  serial multiplier bit to the core.
- spm_prod  in  1  serial product bit from the core.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst.
- Reset values: state IDLE, busy 0, done 0, product 0, spm_x 0, spm_y 0, bit counter 0. spm_rst = rst OR (state==CLEAR), combinational.
- State machine (IDLE, CLEAR, SHIFT, DONE):
  - IDLE: start=1 latches mcand into spm_x and mplier into mreg, clears product, then moves to CLEAR.
  - CLEAR: one cycle; spm_rst=1 flushes the core's carry/sum flops; counter c←0; moves to SHIFT.
  - SHIFT: runs for exactly 2N+SPM_LAT cycles, c = 0 .. 2N+SPM_LAT−1.
    - spm_y = mreg[c] for c<N; mreg[N−1] (sign) for N≤c<2N; 0 for c≥2N.
    - For c≥SPM_LAT: product ← {spm_prod, product[2N−1:1]} (right shift, MSB-in).
    - After the last cycle, moves to DONE.
  - DONE: done=1 for one cycle, busy=0, then returns to IDLE.
- Latency: with start accepted in cycle 0, done is asserted in cycle 2N+SPM_LAT+2. For N=8, SPM_LAT=1, done is in cycle 19.
- busy is 1 in CLEAR and SHIFT, and 0 in IDLE and DONE.
- start while not in IDLE is ignored; no queuing.
- start in the same cycle as done: ignored, because the FSM is in DONE. The next start is accepted one cycle later.
- spm_x is held constant for the whole operation.
- product is not required to be meaningful during SHIFT. It is stable from done until the next accepted start.
- rst mid-operation: the next state is IDLE with all reset values, and spm_rst is asserted in that cycle.
- Arithmetic: product equals the exact signed 2N-bit result mcand×mplier. The core with its MSB complement cell plus sign-extension of y gives two's-complement behaviour.
- Counter width: $clog2(2N+SPM_LAT+1).

Optional Feature:
- Macro: SPM_SEQ_CTRL_OVF_EN.
- When defined: adds output port ovf (1 bit). It is computed in the DONE cycle and held with product. ovf=1 iff product[2N−1:N−1] is not all-equal, i.e. the result does not fit in N signed bits. It resets to 0 and is cleared on an accepted start.
- When undefined: no ovf port and no extra logic; behaviour is otherwise identical.

Decomposition:
- Shared package spm_pkg holds:
  - FSM state typedef spm_state_t (IDLE, CLEAR, SHIFT, DONE), 2-bit encoding.
  - Function spm_cnt_w(N, LAT) for the counter width.
- Optional sub-module spm_deser: 2N-bit shift-in register with enable and clear, reusable for other serial result paths.
- The core multiplier is instantiated at the integration level, not inside this block. This keeps the block verifiable against a behavioural core model.

Test Plan:
- Basic unsigned case (N=8, SPM_LAT=1, behavioural core): mcand=3, mplier=5 → product=0x000F; done exactly in cycle 19; busy high in cycles 1–18.
- Negative multiplicand: mcand=−3 (0xFD), mplier=5 → product=0xFFF1. With OVF_EN: ovf=0.
- Extreme operands: mcand=0x80, mplier=0x80 → product=0x4000. With OVF_EN: ovf=1. Also mcand=0x7F, mplier=0xFF → product=0xFF81, ovf=0.
- Busy and back-to-back starts:
  - start held high continuously → second operation accepted in cycle 20.
  - start pulses in cycles 5 and 19 → ignored.
  - product stays at the first result until the second result's done.
- Reset mid-operation: rst in cycle 10 → cycle 11 shows busy=0, done=0, product=0, spm_rst=1 during rst. A following start gives a correct result (−7×−9 → 0x003F).
- Latency parameter: SPM_LAT=3 with a core model delayed to match → the same results as above, with done in cycle 21.
